// File: rtl/accum_accum_sched_pkg.sv
// Shared widths and arithmetic helper for the accumulator job scheduler.
// State encodings stay local to the scheduler; this package holds no typedefs.
package accum_accum_sched_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NUM_REQ = 2;

    // Per-job sum from a free-running accumulator; wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] job_delta(input logic [DATA_W-1:0] now_val,
                                                    input logic [DATA_W-1:0] base_val);
        return now_val - base_val;
    endfunction

endpackage

// File: rtl/accum_accum_sched_arb2.sv
// Two-input round-robin arbiter. The pointer favours the requester that was
// not granted last and only moves when a grant is actually issued.
module accum_accum_sched_arb2
    import accum_accum_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] reqs,
    input  logic               en,
    output logic [NUM_REQ-1:0] grants
);

    logic ptr_reg;  // 0: requester 0 favoured, 1: requester 1 favoured

    always_comb begin
        grants = '0;
        if (en) begin
            if (reqs == 2'b11) begin
                grants = ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grants = reqs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (|grants) begin
            // Granting requester 0 hands priority to requester 1 and vice versa.
            ptr_reg <= grants[0];
        end
    end

endmodule

// File: rtl/accum_accum_sched.sv
// Schedules jobs from two requesters onto a single accumulator unit and
// returns each job's sum, derived from the accumulator's cumulative result.
module accum_accum_sched
    import accum_accum_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic [ADDR_W-1:0] req0_base_addr,
    input  logic [DATA_W-1:0] req0_size,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic [ADDR_W-1:0] req1_base_addr,
    input  logic [DATA_W-1:0] req1_size,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_id,
    output logic              accum_go,
    output logic [ADDR_W-1:0] accum_base_addr,
    output logic [DATA_W-1:0] accum_size,
    input  logic              accum_done,
    input  logic [DATA_W-1:0] accum_result
);

    // Three-bit encoding leaves spare codes so a corrupted state can recover.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GO   = 3'd1;
    localparam logic [2:0] ST_BUSY = 3'd2;
    localparam logic [2:0] ST_RESP = 3'd3;

    logic [2:0]         state_reg;
    logic [2:0]         state_next;
    logic [NUM_REQ-1:0] req_vals;
    logic [NUM_REQ-1:0] grants;
    logic               accept;
    logic               grant_id;
    logic [ADDR_W-1:0]  sel_base;
    logic [DATA_W-1:0]  sel_size;
    logic [ADDR_W-1:0]  base_reg;
    logic [DATA_W-1:0]  size_reg;
    logic               id_reg;
    logic [DATA_W-1:0]  baseline_reg;
    logic [DATA_W-1:0]  result_reg;

    assign req_vals = {req1_val, req0_val};

    accum_accum_sched_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .reqs   (req_vals),
        .en     (state_reg == ST_IDLE),
        .grants (grants)
    );

    assign accept   = |grants;
    assign grant_id = grants[1];
    assign sel_base = grant_id ? req1_base_addr : req0_base_addr;
    assign sel_size = grant_id ? req1_size : req0_size;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (sel_size == '0) ? ST_RESP : ST_GO;
                end
            end
            ST_GO:   state_next = ST_BUSY;
            ST_BUSY: begin
                if (accum_done) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_rdy = grants[0];
        req1_rdy = grants[1];
        accum_go = (state_reg == ST_GO);
        resp_val = (state_reg == ST_RESP);
    end

    // Job parameters, baseline snapshot and per-job result.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_reg     <= '0;
            size_reg     <= '0;
            id_reg       <= 1'b0;
            baseline_reg <= '0;
            result_reg   <= '0;
        end else begin
            if (accept) begin
                base_reg <= sel_base;
                size_reg <= sel_size;
                id_reg   <= grant_id;
                if (sel_size == '0) begin
                    result_reg <= '0;
                end
            end
            if (state_reg == ST_GO) begin
                baseline_reg <= accum_result;
            end
            if ((state_reg == ST_BUSY) && accum_done) begin
                result_reg <= job_delta(accum_result, baseline_reg);
            end
        end
    end

    assign accum_base_addr = base_reg;
    assign accum_size      = size_reg;
    assign resp_result     = result_reg;
    assign resp_id         = id_reg;

endmodule
